// File: rtl/lc_tune_pkg.sv
// Shared types and defaults for the LC tank SAR tuning controller.
package lc_tune_pkg;

    localparam int unsigned DEF_NBITS    = 6;
    localparam int unsigned DEF_SETTLE_W = 8;
    localparam int unsigned DEF_CODE_VAL = 32;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StMeasure,
        StDone
    } tune_state_e;

    function automatic int unsigned msb_code(input int unsigned n);
        return 32'd1 << (n - 1);
    endfunction

endpackage

// File: rtl/lc_settle_timer.sv
// Down-counter that holds off the comparator sample while the tank settles.
module lc_settle_timer #(
    parameter int unsigned SETTLE_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    input  logic                en,
    output logic                expired
);

    logic [SETTLE_W-1:0] count_q;

    assign expired = (count_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && !expired) begin
            count_q <= count_q - SETTLE_W'(1);
        end
    end

endmodule

// File: rtl/lc_tune_ctrl.sv
// SAR search over a binary-weighted cap bank: one comparator verdict per bit, MSB first,
// with manual load and an abort that restores the code held before the search began.
module lc_tune_ctrl
    import lc_tune_pkg::*;
#(
    parameter int unsigned NBITS    = DEF_NBITS,
    parameter int unsigned SETTLE_W = DEF_SETTLE_W,
    parameter int unsigned DEF_CODE = DEF_CODE_VAL
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [SETTLE_W-1:0] settle_cycles,
    input  logic                cmp_valid,
    input  logic                cmp_high,
    input  logic                manual_en,
    input  logic [NBITS-1:0]    manual_code,
    output logic [NBITS-1:0]    cap_code,
    output logic                busy,
    output logic                done
);

    localparam int unsigned IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;

    tune_state_e      state_q, state_d;
    logic [NBITS-1:0] cap_code_q, cap_code_d;
    logic [NBITS-1:0] saved_q, saved_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic             busy_q, done_q;
    logic             tmr_load, tmr_en, tmr_expired;

    lc_settle_timer #(
        .SETTLE_W (SETTLE_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (settle_cycles),
        .en       (tmr_en),
        .expired  (tmr_expired)
    );

    always_comb begin
        state_d    = state_q;
        cap_code_d = cap_code_q;
        saved_d    = saved_q;
        bit_idx_d  = bit_idx_q;
        tmr_load   = 1'b0;
        tmr_en     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    saved_d    = cap_code_q;
                    cap_code_d = NBITS'(msb_code(NBITS));
                    bit_idx_d  = IDX_W'(NBITS - 1);
                    tmr_load   = 1'b1;
                    state_d    = StSettle;
                end else if (manual_en) begin
                    cap_code_d = manual_code;
                end
            end
            StSettle: begin
                if (abort) begin
                    cap_code_d = saved_q;
                    state_d    = StIdle;
                end else if (tmr_expired) begin
                    state_d = StMeasure;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            StMeasure: begin
                // Abort outranks a verdict arriving in the same cycle.
                if (abort) begin
                    cap_code_d = saved_q;
                    state_d    = StIdle;
                end else if (cmp_valid) begin
                    cap_code_d[bit_idx_q] = cmp_high;
                    if (bit_idx_q == '0) begin
                        state_d = StDone;
                    end else begin
                        cap_code_d[bit_idx_q - IDX_W'(1)] = 1'b1;
                        bit_idx_d = bit_idx_q - IDX_W'(1);
                        tmr_load  = 1'b1;
                        state_d   = StSettle;
                    end
                end
            end
            StDone: begin
                if (abort) begin
                    cap_code_d = saved_q;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cap_code_q <= NBITS'(DEF_CODE);
            saved_q    <= NBITS'(DEF_CODE);
            bit_idx_q  <= IDX_W'(NBITS - 1);
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cap_code_q <= cap_code_d;
            saved_q    <= saved_d;
            bit_idx_q  <= bit_idx_d;
            busy_q     <= (state_d == StSettle) || (state_d == StMeasure);
            done_q     <= (state_d == StDone);
        end
    end

    assign cap_code = cap_code_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_lc_tune_ctrl.sv
// Randomized and directed checks of lc_tune_ctrl against an arithmetic SAR model.
module tb_lc_tune_ctrl;

    localparam int NB = 6;
    localparam int SW = 8;
    localparam int DC = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [SW-1:0] settle_cycles = 8'd2;
    logic          cmp_valid = 1'b0;
    logic          cmp_high = 1'b0;
    logic          manual_en = 1'b0;
    logic [NB-1:0] manual_code = '0;
    logic [NB-1:0] cap_code;
    logic          busy;
    logic          done;

    lc_tune_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .settle_cycles (settle_cycles),
        .cmp_valid     (cmp_valid),
        .cmp_high      (cmp_high),
        .manual_en     (manual_en),
        .manual_code   (manual_code),
        .cap_code      (cap_code),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int target = 0;
    int cv_mode = 0;
    int meas_cnt = 0;

    // Model: code as an integer, bit under trial, clocks left before a verdict can be taken.
    int m_code, m_saved, m_bit, m_left;
    bit m_busy, m_done, m_was_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_code = DC; m_saved = DC; m_bit = NB - 1; m_left = 0;
            m_busy = 1'b0; m_done = 1'b0;
        end else begin
            m_was_done = m_done;
            m_done = 1'b0;
            if ((m_busy || m_was_done) && abort) begin
                m_code = m_saved;
                m_busy = 1'b0;
            end else if (m_busy) begin
                if (m_left > 0) begin
                    m_left--;
                end else if (cmp_valid) begin
                    if (!cmp_high) m_code -= (1 << m_bit);
                    if (m_bit == 0) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end else begin
                        m_bit--;
                        m_code += (1 << m_bit);
                        m_left = int'(settle_cycles) + 1;
                    end
                end
            end else if (!m_was_done) begin
                if (start) begin
                    m_saved = m_code;
                    m_code = 1 << (NB - 1);
                    m_bit = NB - 1;
                    m_left = int'(settle_cycles) + 1;
                    m_busy = 1'b1;
                end else if (manual_en) begin
                    m_code = int'(manual_code);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        vectors++;
        if (cap_code !== m_code[NB-1:0] || busy !== m_busy || done !== m_done) begin
            miscompares++;
            $display("FAIL cycle_check t=%0t: got code=%0d busy=%b done=%b, want code=%0d busy=%b done=%b",
                     $time, cap_code, busy, done, m_code, m_busy, m_done);
        end
        if (done === 1'b1) done_cnt++;
    end

    // Comparator stand-in: monotonic in the model's code; validity pattern set by cv_mode.
    always @(negedge clk) begin
        cmp_high = (m_code <= target);
        meas_cnt = (m_busy && m_left == 0) ? meas_cnt + 1 : 0;
        case (cv_mode)
            0: cmp_valid = 1'b1;
            1: cmp_valid = 1'($urandom_range(0, 1));
            default: cmp_valid = (meas_cnt > 5);
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic run_search(input int bound, output int lat);
        @(negedge clk);
        start = 1'b1;
        lat = -1;
        for (int k = 1; k <= bound; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin
                lat = k - 1;
                break;
            end
        end
    endtask

    task automatic wait_bit(input int b, input string name);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (m_busy && m_left == 0 && m_bit == b) begin
                hit = 1'b1;
                break;
            end
        end
        chk(name, int'(hit), 1);
    endtask

    int lat, d0;

    initial begin
        // Reset and idle hold
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_code", int'(cap_code), 32);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_hold_code", int'(cap_code), 32);
        chk("idle_hold_busy", int'(busy), 0);

        // Basic SAR: 32,48,40,36,38,37
        target = 37; settle_cycles = 8'd2; cv_mode = 0;
        run_search(200, lat);
        chk("sar37_latency", lat, 24);
        chk("sar37_code", int'(cap_code), 37);
        chk("sar37_busy", int'(busy), 0);

        // Extremes with zero settle
        settle_cycles = 8'd0; target = 63;
        run_search(200, lat);
        chk("all_high_latency", lat, 12);
        chk("all_high_code", int'(cap_code), 63);
        target = -1;
        run_search(200, lat);
        chk("all_low_latency", lat, 12);
        chk("all_low_code", int'(cap_code), 0);

        // Manual load, then abort alongside the bit-3 verdict
        @(negedge clk);
        manual_en = 1'b1; manual_code = 6'd17;
        @(negedge clk);
        manual_en = 1'b0;
        chk("manual_code", int'(cap_code), 17);
        target = 37; settle_cycles = 8'd2; cv_mode = 0;
        start = 1'b1;
        wait_bit(3, "reach_bit3");
        d0 = done_cnt;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_code", int'(cap_code), 17);
        chk("abort_busy", int'(busy), 0);
        repeat (4) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_hold", int'(cap_code), 17);

        // Slow comparator, redundant start mid-search
        cv_mode = 2; settle_cycles = 8'd1; target = 21;
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        lat = -1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            start = (k == 10);
            if (done === 1'b1) begin
                lat = k - 1;
                break;
            end
        end
        start = 1'b0;
        chk("slow_latency", lat, 48);
        chk("slow_code", int'(cap_code), 21);
        repeat (3) @(negedge clk);
        chk("slow_done_once", done_cnt - d0, 1);

        // Reset during bit 2, then a clean search
        cv_mode = 0; settle_cycles = 8'd2; target = 37;
        @(negedge clk);
        start = 1'b1;
        wait_bit(2, "reach_bit2");
        rst_n = 1'b0;
        #1;
        chk("midreset_code", int'(cap_code), 32);
        chk("midreset_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_search(200, lat);
        chk("after_reset_latency", lat, 24);
        chk("after_reset_code", int'(cap_code), 37);

        // Random traffic against the model
        cv_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start         = ($urandom_range(0, 9) == 0);
            abort         = ($urandom_range(0, 39) == 0);
            manual_en     = ($urandom_range(0, 7) == 0);
            manual_code   = NB'($urandom);
            settle_cycles = SW'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) target = int'($urandom_range(0, 64)) - 1;
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0; manual_en = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
